// File: rtl/coder_round_scheduler.sv
// coder_round_scheduler
// Control block for the iterative 64-bit Magma/GOST round datapath. It holds
// the 256-bit key and the encrypt/decrypt mode, and accepts one block per
// stream-slave handshake. It then steps the datapath through 32 rounds,
// supplying the subkey for each one, and presents the result on the
// stream-master handshake. Block data does not pass through this block.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   key_i, mode_i       key and mode (0 enc / 1 dec), captured on key_load_i
//   key_load_i          capture request; key_rej_o pulses if a block is busy
//   ss_tvalid_i/ss_tready_o   input block handshake (ready is combinational)
//   sm_tvalid_o/sm_tready_i   output block handshake
//   dp_load_o           datapath loads N1/N2 (combinational, input handshake)
//   dp_round_o, dp_key_o, dp_idx_o, dp_last_o   per-round datapath strobes
//   blk_cnt_o           completed output handshakes, modulo 2^16
module coder_round_scheduler #(
  parameter int TDATA_WIDTH = 64,
  parameter int KEY_WIDTH   = 256,
  parameter int K_WIDTH     = 32,
  parameter int ROUNDS      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [KEY_WIDTH-1:0] key_i,
  input  logic                 mode_i,
  input  logic                 key_load_i,
  output logic                 key_rej_o,
  input  logic                 ss_tvalid_i,
  output logic                 ss_tready_o,
  output logic                 sm_tvalid_o,
  input  logic                 sm_tready_i,
  output logic                 dp_load_o,
  output logic                 dp_round_o,
  output logic [K_WIDTH-1:0]   dp_key_o,
  output logic [4:0]           dp_idx_o,
  output logic                 dp_last_o,
  output logic [15:0]          blk_cnt_o
);

  localparam int NK = KEY_WIDTH / K_WIDTH;

  // The datapath splits a block into two subkey-wide halves.
  if (K_WIDTH * 2 != TDATA_WIDTH || NK != 8) begin : g_bad_cfg
    $error("coder_round_scheduler: unsupported width configuration");
  end

  typedef enum logic [1:0] {S_IDLE, S_READY, S_ROUND, S_HOLD} state_t;

  state_t                      state_q, state_d;
  logic [NK-1:0][K_WIDTH-1:0]  key_q;   // key_q[7] = K0 ... key_q[0] = K7
  logic                        mode_q;
  logic [4:0]                  idx_q, idx_d;
  logic                        kcap;

  // Subkey for round r. K[j] lives at key_q[7-j] = key_q[~j], so the
  // reversed half of the schedule (K[7-j]) indexes key_q[j] directly.
  function automatic logic [K_WIDTH-1:0] subkey(input logic [4:0] r);
    logic       rev;
    logic [2:0] sel;
    rev = mode_q ? (r >= 5'd8) : (r >= 5'd24);
    sel = rev ? r[2:0] : ~r[2:0];
    return key_q[sel];
  endfunction

  always_comb begin
    state_d     = state_q;
    ss_tready_o = 1'b0;
    dp_load_o   = 1'b0;
    kcap        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (key_load_i) begin
          kcap    = 1'b1;
          state_d = S_READY;
        end
      end
      S_READY: begin
        // a key load in the same cycle wins over the block
        ss_tready_o = !key_load_i;
        kcap        = key_load_i;
        dp_load_o   = ss_tvalid_i && !key_load_i;
        if (dp_load_o) state_d = S_ROUND;
      end
      S_ROUND: if (idx_q == 5'(ROUNDS - 1)) state_d = S_HOLD;
      S_HOLD:  if (sm_tready_i) state_d = S_READY;
      default: state_d = S_IDLE;
    endcase
  end

  // Round index of the next cycle: restarts at 0 on entry to ROUND.
  assign idx_d    = (state_q == S_ROUND) ? idx_q + 5'd1 : 5'd0;
  assign dp_idx_o = idx_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      mode_q      <= 1'b0;
      idx_q       <= '0;
      dp_round_o  <= 1'b0;
      dp_key_o    <= '0;
      dp_last_o   <= 1'b0;
      sm_tvalid_o <= 1'b0;
      key_rej_o   <= 1'b0;
      blk_cnt_o   <= '0;
    end else begin
      state_q <= state_d;
      if (kcap) begin
        key_q  <= key_i;
        mode_q <= mode_i;
      end
      key_rej_o   <= key_load_i && (state_q == S_ROUND || state_q == S_HOLD);
      // round strobes are registered from the next state so that they line
      // up with the cycle the datapath executes the round
      dp_round_o  <= (state_d == S_ROUND);
      idx_q       <= (state_d == S_ROUND) ? idx_d : 5'd0;
      dp_key_o    <= (state_d == S_ROUND) ? subkey(idx_d) : '0;
      dp_last_o   <= (state_d == S_ROUND) && (idx_d == 5'(ROUNDS - 1));
      sm_tvalid_o <= (state_d == S_HOLD);
      if (state_q == S_HOLD && sm_tready_i) blk_cnt_o <= blk_cnt_o + 16'd1;
    end
  end

endmodule
